// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer.
package counter_seq_pkg;

    localparam int CNT_WIDTH  = 4;
    localparam int CNT_STEP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        CHECK = 2'd3
    } state_e;

    // One latched requester command, sized by the package defaults.
    typedef struct packed {
        logic                  dir;
        logic [CNT_WIDTH-1:0]  start;
        logic [CNT_STEP_W-1:0] steps;
    } cmd_t;

    // Value the counter must hold after the command ran; wraps mod 2**CNT_WIDTH.
    function automatic logic [CNT_WIDTH-1:0] expected_final(input cmd_t cmd);
        logic [CNT_WIDTH-1:0] delta;
        delta = cmd.steps[CNT_WIDTH-1:0];
        return cmd.dir ? (cmd.start + delta) : (cmd.start - delta);
    endfunction

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Combinational only; the parent keeps the
// last-served pointer.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt_oh
);

    // A lone requester wins; on a tie the one not served last wins.
    always_comb begin
        gnt_oh = 2'b00;
        case (req)
            2'b01:   gnt_oh = 2'b01;
            2'b10:   gnt_oh = 2'b10;
            2'b11:   gnt_oh = last ? 2'b01 : 2'b10;
            default: gnt_oh = 2'b00;
        endcase
    end

endmodule

// File: rtl/counter_sequencer.sv
// Sequences the shared up/down counter for two requesters: arbitrate, load,
// count for the requested number of cycles, then verify the final value.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | waiting; requests are sampled and arbitrated only here
//  LOAD  | grant pulse, counter load strobe with the latched start value
//  RUN   | counter enabled; internal down-counter tracks remaining steps
//  CHECK | done pulse to owner; compare counter against expected value
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH  = CNT_WIDTH,
    parameter int STEP_W = CNT_STEP_W
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          req_dir,
    input  logic [2*WIDTH-1:0]  req_start,
    input  logic [2*STEP_W-1:0] req_steps,
    input  logic                abort,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic                busy,
    output logic                err,
    output logic                cnt_load,
    output logic [WIDTH-1:0]    cnt_load_val,
    output logic                cnt_en,
    output logic                cnt_dir,
    input  logic [WIDTH-1:0]    cnt_q
);

    state_e              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    cmd_t                cand;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic [1:0]          win_oh;
    logic                win_idx;

    logic [1:0]          gnt_d, done_d;
    logic                busy_d, err_d, load_d, en_d, dir_d;
    logic [WIDTH-1:0]    load_val_d;

    rr_arb2 u_arb (
        .req    (req),
        .last   (last_q),
        .gnt_oh (win_oh)
    );

    assign win_idx = win_oh[1];

    // Command fields of the arbitration winner.
    always_comb begin
        cand       = '0;
        cand.dir   = req_dir[win_idx];
        cand.start = win_idx ? req_start[2*WIDTH-1:WIDTH] : req_start[WIDTH-1:0];
        cand.steps = win_idx ? req_steps[2*STEP_W-1:STEP_W] : req_steps[STEP_W-1:0];
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        owner_d    = owner_q;
        last_d     = last_q;
        rem_d      = rem_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        load_d     = 1'b0;
        load_val_d = '0;
        en_d       = 1'b0;
        dir_d      = 1'b0;
        err_d      = err;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = LOAD;
                    cmd_d      = cand;
                    owner_d    = win_idx;
                    gnt_d      = win_oh;
                    load_d     = 1'b1;
                    load_val_d = cand.start;
                    dir_d      = cand.dir;
                end
            end
            LOAD: begin
                dir_d = cmd_q.dir;
                if (abort) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    dir_d   = 1'b0;
                end else if (cmd_q.steps == '0) begin
                    state_d = CHECK;
                    done_d  = owner_onehot(owner_q);
                end else begin
                    state_d = RUN;
                    en_d    = 1'b1;
                    rem_d   = cmd_q.steps;
                end
            end
            RUN: begin
                dir_d = cmd_q.dir;
                if (abort) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    dir_d   = 1'b0;
                end else if (rem_q == STEP_W'(1)) begin
                    // Last enabled cycle: drop enable and report next cycle.
                    state_d = CHECK;
                    done_d  = 2'b00;
                    done_d  = owner_onehot(owner_q);
                end else begin
                    en_d  = 1'b1;
                    rem_d = rem_q - STEP_W'(1);
                end
            end
            CHECK: begin
                if (cnt_q != expected_final(cmd_q)) begin
                    err_d = 1'b1;
                end
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, command latch and registered outputs.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            owner_q      <= 1'b0;
            // Treat requester 1 as last served so requester 0 wins the first tie.
            last_q       <= 1'b1;
            rem_q        <= '0;
            gnt          <= 2'b00;
            done         <= 2'b00;
            busy         <= 1'b0;
            err          <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            cnt_en       <= 1'b0;
            cnt_dir      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            rem_q        <= rem_d;
            gnt          <= gnt_d;
            done         <= done_d;
            busy         <= busy_d;
            err          <= err_d;
            cnt_load     <= load_d;
            cnt_load_val <= load_val_d;
            cnt_en       <= en_d;
            cnt_dir      <= dir_d;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: closes the loop with a 4-bit counter and
// checks grants and completions through expectation queues.
`timescale 1ns/1ps
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam int W = 4;
    localparam int S = 8;

    logic           CLK = 1'b0;
    logic           reset;
    logic [1:0]     req, req_dir;
    logic [2*W-1:0] req_start;
    logic [2*S-1:0] req_steps;
    logic           abort;
    logic [1:0]     gnt, done;
    logic           busy, err, cnt_load, cnt_en, cnt_dir;
    logic [W-1:0]   cnt_load_val, cnt_q;
    logic           hold_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gnt_cyc  = 0;
    int en_total = 0;

    typedef struct {
        logic [1:0]   oh;
        logic [W-1:0] q;
        int           steps;
    } done_t;

    logic [1:0] gnt_q[$];
    done_t      done_q[$];

    counter_sequencer #(.WIDTH(W), .STEP_W(S)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .req          (req),
        .req_dir      (req_dir),
        .req_start    (req_start),
        .req_steps    (req_steps),
        .abort        (abort),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .err          (err),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_en       (cnt_en),
        .cnt_dir      (cnt_dir),
        .cnt_q        (cnt_q)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // External counter datapath; hold_cnt lets the bench swallow one enable.
    always @(posedge CLK or posedge reset) begin
        if (reset)                     cnt_q <= '0;
        else if (cnt_load)             cnt_q <= cnt_load_val;
        else if (cnt_en && !hold_cnt)  cnt_q <= cnt_dir ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT pulses gnt or done.
    always @(negedge CLK) begin
        done_t d;
        if (!reset) begin
            if (cnt_en) en_total++;
            if (gnt != 2'b00) begin
                if (gnt_q.size() == 0) check("gnt_unexpected", int'(gnt), 0);
                else                   check("gnt_owner", int'(gnt), int'(gnt_q.pop_front()));
                gnt_cyc = cyc;
            end
            if (done != 2'b00) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", int'(done), 0);
                end else begin
                    d = done_q.pop_front();
                    check("done_owner", int'(done), int'(d.oh));
                    check("done_cnt_q", int'(cnt_q), int'(d.q));
                    check("done_latency", cyc - gnt_cyc, d.steps + 1);
                end
            end
        end
    end

    task automatic set_cmd(input int idx, input logic [W-1:0] start, input logic dir,
                           input logic [S-1:0] steps);
        req_start[idx*W +: W] = start;
        req_dir[idx]          = dir;
        req_steps[idx*S +: S] = steps;
    endtask

    task automatic expect_cmd(input logic [1:0] oh, input logic [W-1:0] q, input int steps,
                              input bit completes);
        done_t d;
        gnt_q.push_back(oh);
        if (completes) begin
            d.oh = oh; d.q = q; d.steps = steps;
            done_q.push_back(d);
        end
    endtask

    task automatic wait_gnt(input int idx, output int at);
        int k = 0;
        at = -1;
        while (k < 300) begin
            @(negedge CLK);
            k++;
            if (gnt[idx]) begin
                at = cyc;
                req[idx] = 1'b0;
                break;
            end
        end
        check($sformatf("gnt%0d_seen", idx), int'(at >= 0), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while ((busy || done_q.size() != 0) && k < 400);
        check("idle_reached", int'(!busy && done_q.size() == 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int at, c0, e0;
        reset = 1'b1; req = 2'b00; req_dir = 2'b00; req_start = '0; req_steps = '0;
        abort = 1'b0; hold_cnt = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_outputs", int'({gnt, done, busy, err, cnt_load, cnt_en, cnt_dir, cnt_load_val}), 0);
        reset = 1'b0;
        @(negedge CLK);

        // Both requesting from reset: 0 then 1, and again 0 then 1.
        set_cmd(0, 4'd2, 1'b1, 8'd1);
        set_cmd(1, 4'd9, 1'b0, 8'd2);
        expect_cmd(2'b01, 4'd3, 1, 1'b1);
        expect_cmd(2'b10, 4'd7, 2, 1'b1);
        req = 2'b11;
        wait_gnt(0, at);
        wait_gnt(1, at);
        wait_idle();
        set_cmd(0, 4'd0, 1'b1, 8'd3);
        set_cmd(1, 4'd5, 1'b0, 8'd1);
        expect_cmd(2'b01, 4'd3, 3, 1'b1);
        expect_cmd(2'b10, 4'd4, 1, 1'b1);
        req = 2'b11;
        wait_gnt(0, at);
        wait_gnt(1, at);
        wait_idle();

        // Basic command: 3 up 5 -> 8.
        set_cmd(0, 4'd3, 1'b1, 8'd5);
        expect_cmd(2'b01, 4'd8, 5, 1'b1);
        e0 = en_total; c0 = cyc;
        req[0] = 1'b1;
        wait_gnt(0, at);
        check("t1_gnt_delay", at - c0, 1);
        check("t1_load", int'(cnt_load), 1);
        check("t1_load_val", int'(cnt_load_val), 3);
        check("t1_dir", int'(cnt_dir), 1);
        wait_idle();
        check("t1_en_cycles", en_total - e0, 5);
        check("t1_err", int'(err), 0);

        // Wrap-around both ways.
        set_cmd(0, 4'd14, 1'b1, 8'd4);
        expect_cmd(2'b01, 4'd2, 4, 1'b1);
        req[0] = 1'b1;
        wait_gnt(0, at);
        wait_idle();
        check("wrap_up_err", int'(err), 0);
        set_cmd(1, 4'd1, 1'b0, 8'd3);
        expect_cmd(2'b10, 4'd14, 3, 1'b1);
        req[1] = 1'b1;
        wait_gnt(1, at);
        wait_idle();
        check("wrap_dn_err", int'(err), 0);

        // Zero steps: LOAD straight to CHECK.
        set_cmd(0, 4'd11, 1'b1, 8'd0);
        expect_cmd(2'b01, 4'd11, 0, 1'b1);
        e0 = en_total;
        req[0] = 1'b1;
        wait_gnt(0, at);
        wait_idle();
        check("zero_en_cycles", en_total - e0, 0);
        check("zero_err", int'(err), 0);

        // Abort in the second RUN cycle; pending req1 is served next.
        set_cmd(0, 4'd0, 1'b1, 8'd10);
        set_cmd(1, 4'd4, 1'b1, 8'd2);
        expect_cmd(2'b01, 4'd0, 10, 1'b0);
        expect_cmd(2'b10, 4'd6, 2, 1'b1);
        e0 = en_total;
        req[0] = 1'b1;
        wait_gnt(0, at);
        req[1] = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("abort_en_run2", int'(cnt_en), 1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort_en_low", int'(cnt_en), 0);
        check("abort_busy_low", int'(busy), 0);
        check("abort_no_done", int'(done), 0);
        check("abort_en_cycles", en_total - e0, 2);
        wait_gnt(1, at);
        wait_idle();
        check("abort_err", int'(err), 0);

        // Forced mismatch: one enable swallowed, 2 up 4 ends at 5.
        set_cmd(0, 4'd2, 1'b1, 8'd4);
        expect_cmd(2'b01, 4'd5, 4, 1'b1);
        req[0] = 1'b1;
        wait_gnt(0, at);
        @(negedge CLK);
        hold_cnt = 1'b1;
        @(negedge CLK);
        hold_cnt = 1'b0;
        wait_idle();
        check("err_set", int'(err), 1);
        set_cmd(1, 4'd0, 1'b1, 8'd1);
        expect_cmd(2'b10, 4'd1, 1, 1'b1);
        req[1] = 1'b1;
        wait_gnt(1, at);
        wait_idle();
        check("err_sticky", int'(err), 1);

        // Asynchronous reset in the middle of RUN.
        set_cmd(0, 4'd5, 1'b1, 8'd8);
        expect_cmd(2'b01, 4'd13, 8, 1'b1);
        req[0] = 1'b1;
        wait_gnt(0, at);
        repeat (3) @(negedge CLK);
        check("mid_run_en", int'(cnt_en), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_outputs", int'({gnt, done, busy, err, cnt_load, cnt_en, cnt_dir, cnt_load_val}), 0);
        done_q.delete();
        gnt_q.delete();
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);

        // After reset the FSM is idle and req0 wins a tie again.
        set_cmd(0, 4'd7, 1'b0, 8'd2);
        set_cmd(1, 4'd3, 1'b1, 8'd1);
        expect_cmd(2'b01, 4'd5, 2, 1'b1);
        expect_cmd(2'b10, 4'd4, 1, 1'b1);
        req = 2'b11;
        wait_gnt(0, at);
        wait_gnt(1, at);
        wait_idle();
        check("post_rst_err", int'(err), 0);

        check("gnt_q_drained", gnt_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
